// File: rtl/nano_boot_loader_if.sv
// Bus bundle for nano_boot_loader: byte-stream input, CPU-side bus in,
// memory-side bus out, plus CPU reset and status flags.
interface nano_boot_loader_if;
    // Byte stream
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    // CPU side
    logic        cpu_rst;
    logic [7:0]  cpu_address;
    logic [15:0] cpu_dataW;
    logic        cpu_we;
    logic        cpu_ce;
    // Memory side
    logic [7:0]  mem_address;
    logic [15:0] mem_dataW;
    logic        mem_we;
    logic        mem_ce;
    // Status
    logic        loaded;
    logic        error;

    // Loader side
    modport master (
        input  in_valid, in_data, cpu_address, cpu_dataW, cpu_we, cpu_ce,
        output in_ready, cpu_rst, mem_address, mem_dataW, mem_we, mem_ce, loaded, error
    );

    // Environment side (stream source, CPU, memory)
    modport slave (
        output in_valid, in_data, cpu_address, cpu_dataW, cpu_we, cpu_ce,
        input  in_ready, cpu_rst, mem_address, mem_dataW, mem_we, mem_ce, loaded, error
    );
endinterface

// File: rtl/nano_boot_loader.sv
// Program loader for NanoCPU: receives a framed program (count, 16-bit words,
// XOR checksum) over a byte stream, writes it to memory while holding the CPU
// in reset, then either releases the CPU as a bus pass-through or latches an error.
module nano_boot_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input logic               ck,
    input logic               rst,
    nano_boot_loader_if.master bus
);

    localparam logic [2:0] StCount = 3'd0;
    localparam logic [2:0] StHi    = 3'd1;
    localparam logic [2:0] StLo    = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StChk   = 3'd4;
    localparam logic [2:0] StRun   = 3'd5;
    localparam logic [2:0] StErr   = 3'd6;

    logic [2:0]  r_state;
    logic [8:0]  r_cnt;   // word count, 9 bits so that a count byte of 0 means 256
    logic [7:0]  r_ptr;
    logic [7:0]  r_chk;
    logic [15:0] r_word;

    logic        w_in_ready;
    logic        w_accept;
    logic [8:0]  w_ptr_inc;
    logic [7:0]  w_addr;
    logic        w_cpu_rst;
    logic        w_loaded;
    logic        w_error;
    logic [7:0]  w_mem_address;
    logic [15:0] w_mem_dataW;
    logic        w_mem_we;
    logic        w_mem_ce;

    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_ptr_inc = {1'b0, r_ptr} + 9'd1;
    assign w_addr    = BASE_ADDR + r_ptr;

    // Frame parser: state, count, pointer, running checksum and word buffer
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= StCount;
            r_cnt   <= 9'd0;
            r_ptr   <= 8'd0;
            r_chk   <= 8'd0;
            r_word  <= 16'd0;
        end else begin
            case (r_state)
                StCount: begin
                    if (w_accept) begin
                        r_cnt   <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                        r_ptr   <= 8'd0;
                        r_chk   <= 8'd0;
                        r_state <= StHi;
                    end
                end
                StHi: begin
                    if (w_accept) begin
                        r_word[15:8] <= bus.in_data;
                        r_chk        <= r_chk ^ bus.in_data;
                        r_state      <= StLo;
                    end
                end
                StLo: begin
                    if (w_accept) begin
                        r_word[7:0] <= bus.in_data;
                        r_chk       <= r_chk ^ bus.in_data;
                        r_state     <= StWrite;
                    end
                end
                StWrite: begin
                    r_ptr   <= r_ptr + 8'd1;
                    r_state <= (w_ptr_inc == r_cnt) ? StChk : StHi;
                end
                StChk: begin
                    if (w_accept) begin
                        r_state <= (bus.in_data == r_chk) ? StRun : StErr;
                    end
                end
                default: begin
                    // StRun and StErr are terminal until rst
                    r_state <= r_state;
                end
            endcase
        end
    end

    // Outputs decoded from state only; memory bus muxed to the CPU in RUN
    always_comb begin
        w_in_ready    = 1'b0;
        w_cpu_rst     = 1'b1;
        w_loaded      = 1'b0;
        w_error       = 1'b0;
        w_mem_address = w_addr;
        w_mem_dataW   = r_word;
        w_mem_we      = 1'b0;
        w_mem_ce      = 1'b0;
        case (r_state)
            StCount, StHi, StLo, StChk: begin
                w_in_ready = 1'b1;
            end
            StWrite: begin
                w_mem_we = 1'b1;
                w_mem_ce = 1'b1;
            end
            StRun: begin
                w_cpu_rst     = 1'b0;
                w_loaded      = 1'b1;
                w_mem_address = bus.cpu_address;
                w_mem_dataW   = bus.cpu_dataW;
                w_mem_we      = bus.cpu_we;
                w_mem_ce      = bus.cpu_ce;
            end
            StErr: begin
                w_error = 1'b1;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.cpu_rst     = w_cpu_rst;
    assign bus.loaded      = w_loaded;
    assign bus.error       = w_error;
    assign bus.mem_address = w_mem_address;
    assign bus.mem_dataW   = w_mem_dataW;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_ce      = w_mem_ce;

endmodule

// File: tb/tb_nano_boot_loader.sv
// Self-checking bench for nano_boot_loader. Two instances (base 00 and F0) see
// the same byte stream and CPU bus; a memory model per instance records writes
// and is compared with the image computed from the frames that were sent.
module tb_nano_boot_loader;

    logic ck = 1'b0;
    logic rst;
    always #5 ck = ~ck;

    logic        tb_valid;
    logic [7:0]  tb_data;
    logic [7:0]  tb_caddr;
    logic [15:0] tb_cdata;
    logic        tb_cwe;
    logic        tb_cce;
    bit          cpu_noise;

    nano_boot_loader_if if0 ();
    nano_boot_loader_if if1 ();

    assign if0.in_valid    = tb_valid;
    assign if0.in_data     = tb_data;
    assign if0.cpu_address = tb_caddr;
    assign if0.cpu_dataW   = tb_cdata;
    assign if0.cpu_we      = tb_cwe;
    assign if0.cpu_ce      = tb_cce;
    assign if1.in_valid    = tb_valid;
    assign if1.in_data     = tb_data;
    assign if1.cpu_address = tb_caddr;
    assign if1.cpu_dataW   = tb_cdata;
    assign if1.cpu_we      = tb_cwe;
    assign if1.cpu_ce      = tb_cce;

    nano_boot_loader #(.BASE_ADDR(8'h00)) u_dut0 (.ck(ck), .rst(rst), .bus(if0));
    nano_boot_loader #(.BASE_ADDR(8'hF0)) u_dut1 (.ck(ck), .rst(rst), .bus(if1));

    int total = 0;
    int bad   = 0;
    int wr0, wr1;
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] exp0 [256];
    logic [15:0] exp1 [256];
    logic [15:0] wbuf [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory model: bus values are stable mid-cycle, so capture the write at negedge
    always @(negedge ck) begin
        if (if0.mem_we === 1'b1 && if0.mem_ce === 1'b1) begin
            mem0[if0.mem_address] = if0.mem_dataW;
            if (!if0.loaded) begin
                wr0++;
                chk("rdy_in_write0", {31'd0, if0.in_ready}, 32'd0);
            end
        end
        if (if1.mem_we === 1'b1 && if1.mem_ce === 1'b1) begin
            mem1[if1.mem_address] = if1.mem_dataW;
            if (!if1.loaded) wr1++;
        end
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic noise();
        if (cpu_noise) begin
            tb_caddr = 8'($urandom);
            tb_cdata = 16'($urandom);
            tb_cwe   = 1'($urandom_range(1));
            tb_cce   = 1'($urandom_range(1));
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) begin
            mem0[a] = 16'hFFFF;
            mem1[a] = 16'hFFFF;
            exp0[a] = 16'hFFFF;
            exp1[a] = 16'hFFFF;
        end
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 256; a++) begin
            chk($sformatf("%s_m0[%0h]", tag, a), {16'd0, mem0[a]}, {16'd0, exp0[a]});
            chk($sformatf("%s_m1[%0h]", tag, a), {16'd0, mem1[a]}, {16'd0, exp1[a]});
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tb_valid = 1'b0;
        tb_cwe   = 1'b0;
        tb_cce   = 1'b0;
        tick();
        chk("rst_cpu_rst", {31'd0, if0.cpu_rst}, 32'd1);
        chk("rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, if0.mem_we}, 32'd0);
        chk("rst_mem_ce", {31'd0, if0.mem_ce}, 32'd0);
        chk("rst_loaded", {31'd0, if0.loaded}, 32'd0);
        chk("rst_error", {31'd0, if0.error}, 32'd0);
        chk("rst_addr0", {24'd0, if0.mem_address}, 32'h00);
        chk("rst_addr1", {24'd0, if1.mem_address}, 32'hF0);
        chk("rst_word", {16'd0, if0.mem_dataW}, 32'd0);
        rst = 1'b0;
        wr0 = 0;
        wr1 = 0;
    endtask

    // Offer one byte, with optional random idle cycles before it; bounded wait for ready
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        while (gaps && $urandom_range(1) == 0) begin
            tb_valid = 1'b0;
            noise();
            tick();
        end
        tb_valid = 1'b1;
        tb_data  = b;
        n = 0;
        while (!if0.in_ready && n < 20) begin
            noise();
            tick();
            n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            noise();
            tick();
        end
        tb_valid = 1'b0;
        tb_cwe   = 1'b0;
        tb_cce   = 1'b0;
    endtask

    function automatic logic [7:0] xs(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ wbuf[i][15:8] ^ wbuf[i][7:0];
        return x;
    endfunction

    // Word i of a frame lands at base+i (mod 256)
    task automatic model_word(input int i);
        logic [7:0] a;
        a = 8'(i);
        exp0[a] = wbuf[i];
        a = 8'hF0 + 8'(i);
        exp1[a] = wbuf[i];
    endtask

    task automatic load_frame(input int n, input logic [7:0] cnt_b, input logic [7:0] chk_b,
                              input bit gaps, input bit ok);
        send_byte(cnt_b, gaps);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i][15:8], gaps);
            send_byte(wbuf[i][7:0], gaps);
            model_word(i);
            chk("we_in_write", {31'd0, if0.mem_we}, 32'd1);
            chk("ready_in_write", {31'd0, if0.in_ready}, 32'd0);
        end
        tick();
        chk("writes0", wr0, n);
        chk("writes1", wr1, n);
        chk("ready_in_chk", {31'd0, if0.in_ready}, 32'd1);
        send_byte(chk_b, gaps);
        chk("cpu_rst_after_chk0", {31'd0, if0.cpu_rst}, ok ? 32'd0 : 32'd1);
        chk("cpu_rst_after_chk1", {31'd0, if1.cpu_rst}, ok ? 32'd0 : 32'd1);
        chk("loaded_after_chk", {31'd0, if0.loaded}, ok ? 32'd1 : 32'd0);
        chk("error_after_chk", {31'd0, if0.error}, ok ? 32'd0 : 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit good;
        logic [7:0] cb;
        rst       = 1'b1;
        tb_valid  = 1'b0;
        tb_data   = 8'd0;
        tb_caddr  = 8'd0;
        tb_cdata  = 16'd0;
        tb_cwe    = 1'b0;
        tb_cce    = 1'b0;
        cpu_noise = 1'b1;
        clear_mem();

        // Directed frame with good checksum
        do_reset();
        wbuf[0] = 16'h4000; wbuf[1] = 16'h4111; wbuf[2] = 16'h01E3;
        load_frame(3, 8'd3, 8'hF2, 1'b0, 1'b1);
        check_mem("good");

        // Pass-through in RUN; stream bytes must be refused
        tb_caddr = 8'h1E; tb_cdata = 16'hABCD; tb_cwe = 1'b1; tb_cce = 1'b1;
        tb_valid = 1'b1;  tb_data = 8'h55;
        #1;
        chk("run_addr", {24'd0, if0.mem_address}, 32'h1E);
        chk("run_data", {16'd0, if1.mem_dataW}, 32'hABCD);
        chk("run_we", {31'd0, if0.mem_we}, 32'd1);
        chk("run_ce", {31'd0, if1.mem_ce}, 32'd1);
        chk("run_ready", {31'd0, if0.in_ready}, 32'd0);
        tick();
        exp0[8'h1E] = 16'hABCD;
        exp1[8'h1E] = 16'hABCD;
        tb_cwe = 1'b0; tb_cce = 1'b0;
        tb_caddr = 8'h77;
        repeat (3) tick();
        chk("run_still_loaded", {31'd0, if0.loaded}, 32'd1);
        chk("run_addr_follow", {24'd0, if1.mem_address}, 32'h77);
        tb_valid = 1'b0;
        check_mem("run");

        // Bad checksum: sticky error, stream and memory shut off
        clear_mem();
        do_reset();
        load_frame(3, 8'd3, 8'hF3, 1'b0, 1'b0);
        tb_valid = 1'b1;
        repeat (22) begin
            noise();
            tick();
            chk("err_cpu_rst", {31'd0, if0.cpu_rst}, 32'd1);
            chk("err_ready", {31'd0, if0.in_ready}, 32'd0);
            chk("err_we", {31'd0, if1.mem_we}, 32'd0);
            chk("err_error", {31'd0, if1.error}, 32'd1);
        end
        tb_valid = 1'b0; tb_cwe = 1'b0; tb_cce = 1'b0;
        check_mem("err");

        // Same good frame with random idle gaps
        clear_mem();
        do_reset();
        load_frame(3, 8'd3, 8'hF2, 1'b1, 1'b1);
        check_mem("gaps");

        // Random frames, some with corrupted checksum
        repeat (4) begin
            clear_mem();
            do_reset();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            good = ($urandom_range(3) != 0);
            cb = good ? xs(n) : (xs(n) ^ 8'($urandom_range(1, 255)));
            load_frame(n, 8'(n), cb, 1'b1, good);
            check_mem("rand");
        end

        // 256-word frame (count byte 0), address wrap on the F0 instance
        clear_mem();
        do_reset();
        for (int i = 0; i < 256; i++) wbuf[i] = 16'(i);
        load_frame(256, 8'd0, xs(256), 1'b1, 1'b1);
        check_mem("full");
        chk("wrap_F0", {16'd0, mem1[8'hF0]}, 32'h0000);
        chk("wrap_FF", {16'd0, mem1[8'hFF]}, 32'h000F);
        chk("wrap_00", {16'd0, mem1[8'h00]}, 32'h0010);
        chk("wrap_EF", {16'd0, mem1[8'hEF]}, 32'h00FF);

        // Reset after the second word: words kept, then a full reload
        clear_mem();
        do_reset();
        wbuf[0] = 16'h1234; wbuf[1] = 16'h5678; wbuf[2] = 16'h9ABC;
        send_byte(8'd3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            send_byte(wbuf[i][15:8], 1'b1);
            send_byte(wbuf[i][7:0], 1'b1);
            model_word(i);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_cpu_rst", {31'd0, if0.cpu_rst}, 32'd1);
        chk("mid_ready", {31'd0, if0.in_ready}, 32'd1);
        chk("mid_loaded", {31'd0, if1.loaded}, 32'd0);
        chk("mid_addr1", {24'd0, if1.mem_address}, 32'hF0);
        chk("mid_writes", wr0, 2);
        check_mem("mid");
        wr0 = 0;
        wr1 = 0;
        for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
        load_frame(3, 8'd3, xs(3), 1'b1, 1'b1);
        check_mem("reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nano_boot_loader.md
# nano_boot_loader

Program loader that sits between an external byte stream and the NanoCPU memory bus, upstream of the CPU. After reset it holds the CPU in reset, receives a framed program (word count, 16-bit words, XOR checksum) over a valid/ready byte interface, and writes the words into the 256 x 16 memory. On a good checksum it releases the CPU and becomes a transparent bus pass-through. On a bad checksum it latches an error and keeps the CPU in reset.

## Interface
- BASE_ADDR, 8'h00, memory address of the first loaded word.
- ck  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  byte-stream data valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte; transfer occurs on an edge where in_valid and in_ready are both 1.
- cpu_rst  out  1  reset to NanoCPU, active-high.
- cpu_address  in  8  CPU bus address.
- cpu_dataW  in  16  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_ce  in  1  CPU chip enable.
- mem_address  out  8  memory address.
- mem_dataW  out  16  memory write data.
- mem_we  out  1  memory write enable; memory writes on rising ck.
- mem_ce  out  1  memory chip enable.
- loaded  out  1  program accepted, CPU running.
- error  out  1  checksum mismatch, sticky until rst.
- Memory read data goes from memory to the CPU directly. This block does not observe it.

## Operation
- States: COUNT, HI, LO, WRITE, CHK, RUN, ERR. Reset state is COUNT.
- COUNT: in_ready=1. On accept, set cnt := in_data, where 0 encodes 256. Set ptr := 0 and chk := 0. Go to HI.
- HI: in_ready=1. On accept, word[15:8] := in_data and chk ^= in_data. Go to LO.
- LO: in_ready=1. On accept, word[7:0] := in_data and chk ^= in_data. Go to WRITE.
- WRITE: in_ready=0, mem_we=1, mem_ce=1, mem_address=BASE_ADDR+ptr (mod 256), mem_dataW=word.
  - Next edge: ptr += 1.
  - If ptr+1 == cnt (9-bit compare, 256 when cnt=0), go to CHK. Otherwise go to HI.
- CHK: in_ready=1. On accept:
  - in_data == chk: go to RUN.
  - Mismatch: go to ERR.
- RUN: in_ready=0, cpu_rst=0, loaded=1. Bus outputs are combinational copies of the cpu_* inputs. Stays in RUN until rst.
- ERR: in_ready=0, cpu_rst=1, error=1, mem_we=0, mem_ce=0. Stays in ERR until rst.
- Outside RUN, cpu_* inputs are ignored.
- Outside WRITE and RUN: mem_we=0, mem_ce=0, mem_address=BASE_ADDR+ptr, mem_dataW=word.
- Address wrap: BASE_ADDR+ptr wraps modulo 256. Example: BASE_ADDR=F0 with 32 words writes F0..FF, then 00..0F.
- Checksum covers data bytes only. The count byte is excluded. An empty program is impossible because count 0 means 256 words.
- in_valid is ignored whenever in_ready=0. Idle cycles (in_valid=0) in any accepting state hold the state.

## Timing
- Reset values, in the cycle after the rst edge: state=COUNT, cpu_rst=1, in_ready=1, mem_we=0, mem_ce=0, loaded=0, error=0, ptr=0, chk=0, word=0.
- cpu_rst, loaded, error, in_ready and the mem_* selects are decoded from the state register only. They never depend combinationally on in_valid.
- Each word takes at least 3 cycles: HI accept, LO accept, WRITE.
- The memory write lands on the edge that ends WRITE.
- Minimum load time is 1 + 3N + 1 cycles.
- cpu_rst falls on the same edge that accepts the matching checksum byte. The CPU sees its first non-reset edge one cycle later.
- rst mid-load: return to COUNT on the next edge. Words already written stay in memory. Partial word and checksum are discarded.
- rst in RUN: re-enter COUNT and reassert cpu_rst; a full reload is required.

## Test plan
- Load N=3, words 4000/4111/01E3, checksum 40^00^41^11^01^E3=F2.
  - Memory 00..02 hold these words.
  - in_ready is 0 in each WRITE cycle.
  - cpu_rst falls on the checksum-accept edge; loaded=1.
- Same frame with checksum F3: error=1 and cpu_rst stays 1 for 20+ cycles. in_ready=0 and mem_we=0 afterwards.
- Random in_valid gaps (about 50% duty) on the N=3 frame: identical memory result. No byte is lost or duplicated.
- BASE_ADDR=F0, count byte 00, 256 words with value = index:
  - Address F0 holds 0000, FF holds 000F, 00 holds 0010, EF holds 00FF.
  - Exactly 256 writes occur, then CHK.
- Assert rst after the second word of a 3-word frame:
  - The loader returns to COUNT, cpu_rst=1, and the 2 words are retained.
  - A full reload then succeeds.
- In RUN, drive cpu_address=1E, cpu_dataW=ABCD, cpu_we=1, cpu_ce=1: mem_* mirror the inputs in the same cycle and memory 1E becomes ABCD. Bytes offered on in_valid are not accepted.
